// File: rtl/rgb_led_seq_pkg.sv
// Shared types and constants for the RGB LED pattern sequencer.
package rgb_led_seq_pkg;

  localparam int TICK_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/rgb_led_seq_tick.sv
// Fade-step tick generator: down-counter that pulses tick_o at zero and reloads from div_i.
module rgb_led_seq_tick
  import rgb_led_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [TICK_W-1:0] div_i,
  output logic              tick_o
);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  // Counter parks at zero while disabled, so the first enabled cycle ticks at once.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = div_i;
    end else begin
      cnt_d = cnt_q - TICK_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/rgb_led_seq.sv
// RGB LED pattern sequencer: fades all channels one LSB per tick toward a table entry, holds, advances.
// Define RGB_LED_SEQ_IRQ_EN to add the wrap_o pulse output.
module rgb_led_seq
  import rgb_led_seq_pkg::*;
#(
  parameter int  n_leds    = 2,
  parameter int  depth     = 8,
  parameter int  n_entries = 4,
  localparam int aw        = $clog2(n_entries),
  localparam int dw        = n_leds * 3 * depth
) (
  input  logic          clk_i,
  input  logic          async_rst_ni,
  input  logic          enable_i,
  input  logic [15:0]   step_div_i,
  input  logic [15:0]   hold_i,
  input  logic [aw-1:0] last_idx_i,
  input  logic          wr_en_i,
  input  logic [aw-1:0] wr_addr_i,
  input  logic [dw-1:0] wr_data_i,
  output logic [dw-1:0] rgb_o,
  output logic [aw-1:0] idx_o,
`ifdef RGB_LED_SEQ_IRQ_EN
  output logic          wrap_o,
`endif
  output logic          busy_o
);

  localparam int               n_ch = n_leds * 3;
  localparam logic [depth-1:0] LSB  = depth'(1);

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  logic              tick_s, adv_s;
  state_e            state_q, state_d;
  logic [dw-1:0]     rgb_q, rgb_d, step_s, tgt_s;
  logic [aw-1:0]     idx_q, idx_d, idx_adv_s;
  logic [TICK_W-1:0] hold_q, hold_d;
  logic              busy_q, busy_d;
  logic [dw-1:0]     pat_q [n_entries];

  // Reset asserts immediately but releases only after two clk_i edges.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  rgb_led_seq_tick u_tick (
    .clk_i    (clk_i),
    .rst_ni   (rst_n),
    .enable_i (enable_i),
    .div_i    (step_div_i),
    .tick_o   (tick_s)
  );

  // Per-channel single-LSB move toward the current target; equal channels stay put.
  always_comb begin
    tgt_s  = pat_q[idx_q];
    step_s = rgb_q;
    for (int c = 0; c < n_ch; c++) begin
      if (rgb_q[c*depth +: depth] < tgt_s[c*depth +: depth]) begin
        step_s[c*depth +: depth] = rgb_q[c*depth +: depth] + LSB;
      end else if (rgb_q[c*depth +: depth] > tgt_s[c*depth +: depth]) begin
        step_s[c*depth +: depth] = rgb_q[c*depth +: depth] - LSB;
      end else begin
        step_s[c*depth +: depth] = rgb_q[c*depth +: depth];
      end
    end
  end

  assign adv_s     = tick_s && (state_q == ST_HOLD) && (hold_q == '0);
  assign idx_adv_s = (idx_q >= last_idx_i) ? '0 : idx_q + aw'(1);

  // Sequencer next-state: disable overrides everything and clears the run state.
  always_comb begin
    state_d = state_q;
    rgb_d   = rgb_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
      rgb_d   = '0;
      idx_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FADE;
          idx_d   = '0;
        end
        ST_FADE: begin
          if (tick_s) begin
            rgb_d = step_s;
            if (step_s == tgt_s) begin
              state_d = ST_HOLD;
              hold_d  = hold_i;
            end else begin
              state_d = ST_FADE;
            end
          end else begin
            rgb_d = rgb_q;
          end
        end
        ST_HOLD: begin
          if (adv_s) begin
            state_d = ST_FADE;
            idx_d   = idx_adv_s;
          end else if (tick_s) begin
            hold_d = hold_q - TICK_W'(1);
          end else begin
            hold_d = hold_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rgb_d   = '0;
          idx_d   = '0;
          hold_d  = '0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rgb_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rgb_q   <= rgb_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  // Pattern table: plain flops, writable in every state, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < n_entries; e++) begin
        pat_q[e] <= '0;
      end
    end else if (wr_en_i) begin
      pat_q[wr_addr_i] <= wr_data_i;
    end
  end

`ifdef RGB_LED_SEQ_IRQ_EN
  logic wrap_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= enable_i && adv_s && (idx_q >= last_idx_i);
    end
  end
  assign wrap_o = wrap_q;
`endif

  assign rgb_o  = rgb_q;
  assign idx_o  = idx_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_rgb_led_seq.sv
// Self-checking bench for rgb_led_seq: vector table, directed corner sequences and a random run
// compared against a behavioural model of the sequencing rules.
module tb_rgb_led_seq;

  localparam int NL = 2, DEP = 8, NE = 4, AW = 2;
  localparam int NCH = NL * 3, DW = NCH * DEP;

  logic          clk = 1'b0;
  logic          async_rst_ni, enable_i, wr_en_i, busy_o;
  logic [15:0]   step_div_i, hold_i;
  logic [AW-1:0] last_idx_i, wr_addr_i, idx_o;
  logic [DW-1:0] wr_data_i, rgb_o;
`ifdef RGB_LED_SEQ_IRQ_EN
  logic          wrap_o;
`endif

  always #5 clk = ~clk;

  rgb_led_seq #(.n_leds(NL), .depth(DEP), .n_entries(NE)) dut (
    .clk_i        (clk),
    .async_rst_ni (async_rst_ni),
    .enable_i     (enable_i),
    .step_div_i   (step_div_i),
    .hold_i       (hold_i),
    .last_idx_i   (last_idx_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .rgb_o        (rgb_o),
    .idx_o        (idx_o),
`ifdef RGB_LED_SEQ_IRQ_EN
    .wrap_o       (wrap_o),
`endif
    .busy_o       (busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: levels as integers, table as a 2-D int array, phases as flags.
  int m_tab [NE][NCH];
  int m_rgb [NCH];
  int m_idx, m_hold, m_wait, m_sync;
  bit m_busy, m_holding, m_wrap, m_in_rst;

  task automatic model_reset();
    for (int e = 0; e < NE; e++) for (int c = 0; c < NCH; c++) m_tab[e][c] = 0;
    for (int c = 0; c < NCH; c++) m_rgb[c] = 0;
    m_idx = 0; m_hold = 0; m_wait = 0; m_sync = 0;
    m_busy = 0; m_holding = 0; m_wrap = 0; m_in_rst = 1;
  endtask

  task automatic model_release();
    m_in_rst = 0;
    m_sync   = 0;
  endtask

  function automatic logic [DW-1:0] m_word();
    logic [DW-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*DEP +: DEP] = DEP'(m_rgb[c]);
    return w;
  endfunction

  task automatic model_edge();
    bit tick, done;
    int tgt;
    m_wrap = 0;
    if (m_in_rst) return;
    if (m_sync < 2) begin
      m_sync++;
      return;
    end
    if (!enable_i) begin
      for (int c = 0; c < NCH; c++) m_rgb[c] = 0;
      m_busy = 0; m_holding = 0; m_idx = 0; m_hold = 0; m_wait = 0;
    end else begin
      tick   = (m_wait == 0);
      m_wait = tick ? int'(step_div_i) : m_wait - 1;
      if (!m_busy) begin
        m_busy = 1; m_holding = 0; m_idx = 0;
      end else if (tick && !m_holding) begin
        done = 1;
        for (int c = 0; c < NCH; c++) begin
          tgt = m_tab[m_idx][c];
          if (m_rgb[c] < tgt) m_rgb[c]++;
          else if (m_rgb[c] > tgt) m_rgb[c]--;
          if (m_rgb[c] != tgt) done = 0;
        end
        if (done) begin
          m_holding = 1;
          m_hold    = int'(hold_i);
        end
      end else if (tick) begin
        if (m_hold == 0) begin
          m_holding = 0;
          m_wrap    = (m_idx >= int'(last_idx_i));
          m_idx     = m_wrap ? 0 : m_idx + 1;
        end else begin
          m_hold--;
        end
      end
    end
    if (wr_en_i) for (int c = 0; c < NCH; c++) m_tab[wr_addr_i][c] = int'(wr_data_i[c*DEP +: DEP]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_rgb", rgb_o, m_word());
    check("model_idx", DW'(idx_o), DW'(m_idx));
    check("model_busy", DW'(busy_o), DW'(m_busy));
`ifdef RGB_LED_SEQ_IRQ_EN
    check("model_wrap", DW'(wrap_o), DW'(m_wrap));
`endif
  endtask

  task automatic write_entry(input int addr, input logic [DW-1:0] data);
    wr_en_i = 1'b1; wr_addr_i = AW'(addr); wr_data_i = data;
    step();
    wr_en_i = 1'b0;
  endtask

  typedef struct {
    bit         en;
    bit         wr;
    logic [7:0] wdat;
    logic [7:0] lvl;
    int         idx;
    bit         busy;
  } vec_t;

  function automatic vec_t mkv(bit en, bit wr, logic [7:0] wdat, logic [7:0] lvl, int idx, bit busy);
    vec_t v;
    v.en = en; v.wr = wr; v.wdat = wdat; v.lvl = lvl; v.idx = idx; v.busy = busy;
    return v;
  endfunction

  vec_t        vecs [15];
  logic [7:0]  lap_lv [4];
  int          exp_seq [5];
  logic [AW-1:0] idx_seq [$];
  logic [AW-1:0] prev_idx;
  logic [7:0]  prev_lvl;
  int          t_first, t_second, nwrap, max_idx;
  bit          found;

  initial begin
    vecs[0]  = mkv(1'b0, 1'b1, 8'h04, 8'h00, 0, 1'b0);
    vecs[1]  = mkv(1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b1);
    vecs[2]  = mkv(1'b1, 1'b0, 8'h00, 8'h01, 0, 1'b1);
    vecs[3]  = mkv(1'b1, 1'b0, 8'h00, 8'h02, 0, 1'b1);
    vecs[4]  = mkv(1'b1, 1'b0, 8'h00, 8'h03, 0, 1'b1);
    vecs[5]  = mkv(1'b1, 1'b0, 8'h00, 8'h04, 0, 1'b1);
    vecs[6]  = mkv(1'b1, 1'b0, 8'h00, 8'h04, 0, 1'b1);
    vecs[7]  = mkv(1'b1, 1'b0, 8'h00, 8'h04, 0, 1'b1);
    vecs[8]  = mkv(1'b1, 1'b0, 8'h00, 8'h04, 0, 1'b1);
    vecs[9]  = mkv(1'b1, 1'b0, 8'h00, 8'h04, 0, 1'b1);
    vecs[10] = mkv(1'b1, 1'b1, 8'h05, 8'h04, 0, 1'b1);
    vecs[11] = mkv(1'b1, 1'b0, 8'h00, 8'h04, 0, 1'b1);
    vecs[12] = mkv(1'b1, 1'b0, 8'h00, 8'h04, 0, 1'b1);
    vecs[13] = mkv(1'b1, 1'b0, 8'h00, 8'h05, 0, 1'b1);
    vecs[14] = mkv(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    lap_lv[0] = 8'hFF; lap_lv[1] = 8'h00; lap_lv[2] = 8'h80; lap_lv[3] = 8'h10;
    exp_seq = '{0, 1, 2, 3, 0};

    async_rst_ni = 1'b0; enable_i = 1'b0; wr_en_i = 1'b0;
    step_div_i = 16'd0; hold_i = 16'd2; last_idx_i = '0; wr_addr_i = '0; wr_data_i = '0;
    model_reset();
    #2;
    check("reset_rgb", rgb_o, '0);
    check("reset_busy", DW'(busy_o), '0);
    step(); step();
    async_rst_ni = 1'b1; model_release();
    step(); step();

    // Ramp 1..4, three hold ticks, re-fade with no change, then a retarget seen after hold.
    for (int i = 0; i < 15; i++) begin
      enable_i = vecs[i].en; wr_en_i = vecs[i].wr; wr_addr_i = '0; wr_data_i = {NCH{vecs[i].wdat}};
      step();
      check($sformatf("vec%0d_rgb", i), rgb_o, {NCH{vecs[i].lvl}});
      check($sformatf("vec%0d_idx", i), DW'(idx_o), DW'(vecs[i].idx));
      check($sformatf("vec%0d_busy", i), DW'(busy_o), DW'(vecs[i].busy));
    end
    wr_en_i = 1'b0;

    // Mixed targets: channel 0 to 3, all others to 1.
    hold_i = 16'd5;
    write_entry(0, {{(NCH-1){8'h01}}, 8'h03});
    enable_i = 1'b1; step();
    step(); check("mix_t1", rgb_o, {{(NCH-1){8'h01}}, 8'h01});
    step(); check("mix_t2", rgb_o, {{(NCH-1){8'h01}}, 8'h02});
    step(); check("mix_t3", rgb_o, {{(NCH-1){8'h01}}, 8'h03});
    step(); check("mix_hold", rgb_o, {{(NCH-1){8'h01}}, 8'h03});

    // Drop enable mid-fade at 0x40, then restart from entry 0.
    enable_i = 1'b0; step();
    write_entry(0, {NCH{8'hFF}});
    hold_i = 16'd0; enable_i = 1'b1; found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      if (rgb_o[7:0] == 8'h40) found = 1;
    end
    check("drop_reach_40", DW'(found), DW'(1));
    enable_i = 1'b0; step();
    check("drop_rgb", rgb_o, '0);
    check("drop_idx", DW'(idx_o), '0);
    check("drop_busy", DW'(busy_o), '0);
    enable_i = 1'b1; step();
    check("restart_busy", DW'(busy_o), DW'(1));
    step(); check("restart_rgb", rgb_o, {NCH{8'h01}});

    // Retarget current entry to 0 mid-upward fade at 0x20.
    enable_i = 1'b0; step();
    write_entry(0, {NCH{8'h40}});
    step_div_i = 16'd3; enable_i = 1'b1; found = 0;
    for (int k = 0; k < 1000 && !found; k++) begin
      step();
      if (rgb_o[7:0] == 8'h20) found = 1;
    end
    check("retgt_reach_20", DW'(found), DW'(1));
    write_entry(0, '0);
    for (int k = 0; k < 10 && rgb_o[7:0] == 8'h20; k++) step();
    check("retgt_next", rgb_o, {NCH{8'h1F}});
    for (int k = 0; k < 400 && rgb_o != '0; k++) step();
    check("retgt_zero", rgb_o, '0);

    // Four-entry lap with step_div=3.
    enable_i = 1'b0; step();
    for (int e = 0; e < 4; e++) write_entry(e, {NCH{lap_lv[e]}});
    last_idx_i = 2'd3; hold_i = 16'd0; enable_i = 1'b1;
    step();
    idx_seq.delete(); idx_seq.push_back(idx_o); prev_idx = idx_o;
    prev_lvl = rgb_o[7:0]; t_first = -1; t_second = -1; nwrap = 0;
    for (int k = 0; k < 6000 && idx_seq.size() < 5; k++) begin
      step();
      if (rgb_o[7:0] != prev_lvl) begin
        if (t_first < 0) t_first = k;
        else if (t_second < 0) t_second = k;
        prev_lvl = rgb_o[7:0];
      end
      if (idx_o != prev_idx) begin
        idx_seq.push_back(idx_o);
        prev_idx = idx_o;
      end
`ifdef RGB_LED_SEQ_IRQ_EN
      if (wrap_o) nwrap++;
`endif
    end
    check("lap_len", DW'(idx_seq.size()), DW'(5));
    for (int i = 0; i < idx_seq.size() && i < 5; i++)
      check($sformatf("lap_idx%0d", i), DW'(idx_seq[i]), DW'(exp_seq[i]));
    check("lap_tick_period", DW'(t_second - t_first), DW'(4));
`ifdef RGB_LED_SEQ_IRQ_EN
    check("lap_wraps", DW'(nwrap), DW'(1));
`endif

    // Randomised run against the model.
    for (int k = 0; k < 1500; k++) begin
      if (k % 50 == 0) begin
        step_div_i = 16'($urandom_range(0, 2));
        hold_i     = 16'($urandom_range(0, 3));
        last_idx_i = AW'($urandom_range(0, 3));
      end
      enable_i  = ($urandom_range(0, 99) < 97);
      wr_en_i   = ($urandom_range(0, 4) == 0);
      wr_addr_i = AW'($urandom_range(0, 3));
      for (int c = 0; c < NCH; c++) wr_data_i[c*DEP +: DEP] = DEP'($urandom_range(0, 31));
      step();
    end
    wr_en_i = 1'b0;

    // Asynchronous reset between edges during HOLD, then synchronised release.
    enable_i = 1'b0; step();
    write_entry(0, {NCH{8'h08}});
    step_div_i = 16'd0; hold_i = 16'd20; last_idx_i = '0; enable_i = 1'b1; found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      if (rgb_o[7:0] == 8'h08) found = 1;
    end
    check("hold_reach_08", DW'(found), DW'(1));
    step(); step();
    #2;
    async_rst_ni = 1'b0; model_reset();
    #1;
    check("async_rgb", rgb_o, '0);
    check("async_idx", DW'(idx_o), '0);
    check("async_busy", DW'(busy_o), '0);
    step(); step();
    last_idx_i = 2'd3; hold_i = 16'd0;
    async_rst_ni = 1'b1; model_release();
    step(); check("sync_edge1_busy", DW'(busy_o), '0);
    step(); check("sync_edge2_busy", DW'(busy_o), '0);
    step(); check("sync_edge3_busy", DW'(busy_o), DW'(1));
    max_idx = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      check("table_zero_rgb", rgb_o, '0);
      if (int'(idx_o) > max_idx) max_idx = int'(idx_o);
    end
    check("table_zero_max_idx", DW'(max_idx), DW'(3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
